// File: rtl/mult_pkg.sv
// mult_pkg: widths, iteration count and FSM states shared by the sequential multiplier
package mult_pkg;
  localparam int A_W = 8;
  localparam int P_W = 2 * A_W;
  localparam int ITER = A_W;
  localparam int C_W = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/adder.sv
// adder: combinational P_W-bit adder; carry-out is dropped since the product never overflows
module adder #(
  parameter int W = mult_pkg::P_W
) (
  input  logic [W-1:0] dataa,
  input  logic [W-1:0] datab,
  output logic [W-1:0] sum
);
  assign sum = dataa + datab;
endmodule

// File: rtl/mult8x8_seq.sv
// mult8x8_seq: 8x8 unsigned shift-and-add multiplier, one partial product per cycle via a shared adder
module mult8x8_seq #(
  parameter int A_W = mult_pkg::A_W,
  parameter int P_W = mult_pkg::P_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [A_W-1:0] dataa,
  input  logic [A_W-1:0] datab,
  output logic [P_W-1:0] product,
  output logic           done,
  output logic           busy
);
  import mult_pkg::*;
  state_t         state_q;
  logic [A_W-1:0] a_q, b_q;
  logic [P_W-1:0] acc_q, product_q, pp, sum;
  logic [C_W-1:0] cnt_q;
  logic           done_q;
  always_comb pp = b_q[cnt_q] ? (P_W'(a_q) << cnt_q) : '0;
  adder #(.W(P_W)) u_add (.dataa(acc_q), .datab(pp), .sum(sum));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE && start) begin
        a_q     <= dataa;
        b_q     <= datab;
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= CALC;
      end else if (state_q == CALC) begin
        acc_q <= sum;
        cnt_q <= cnt_q + 1'b1;
        // last iteration: the final sum is the product, latched as we enter DONE
        if (cnt_q == C_W'(ITER - 1)) begin
          state_q   <= DONE;
          product_q <= sum;
          done_q    <= 1'b1;
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end
  assign product = product_q;
  assign done    = done_q;
  assign busy    = state_q != IDLE;
endmodule
